layer_compositor: RTL and testbench
===================================

LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 Parameter NUM_LAYERS, default 4: number of sprite layers; layer 0 has the highest priority.
REQ-002 Parameter ADDR_W, default 18: sprite ROM address width.
REQ-003 Parameter IDX_W, default 4: palette color-index width.
REQ-004 Parameter LINE_W, default 640: pixels composited per line.
REQ-005 Parameter ROM_LAT, default 2: sprite ROM read latency in cycles, from address to data, with ROM_LAT >= 1.
REQ-006 Parameter TRANSP_IDX, default 0; parameter BG_IDX, default 1: transparent key index and background index.
REQ-007 Port row_Clk, input, 1 bit: block clock; all state is updated on its rising edge.
REQ-008 Port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 Port line_start, input, 1: single-cycle request to composite one line.
REQ-010 Port cur_x, output, 10: pixel column currently being requested from the layer drawers.
REQ-011 Port layer_on, input, NUM_LAYERS: per-layer hit flags for cur_x, combinational from the drawers.
REQ-012 Port layer_addr, input, NUM_LAYERS*ADDR_W: per-layer ROM addresses for cur_x, packed with layer 0 in the LSBs.
REQ-013 Port rom_addr, output, ADDR_W: sprite ROM read address.
REQ-014 Port rom_data, input, IDX_W: ROM color index, valid ROM_LAT cycles after rom_addr.
REQ-015 Port wr_en, output, 1: line-buffer write strobe.
REQ-016 Port wr_x, output, 10: line-buffer write column.
REQ-017 Port wr_data, output, IDX_W: line-buffer write index.
REQ-018 Port buf_sel, output, 1: ping-pong half being written; the reader uses ~buf_sel.
REQ-019 Port busy, output, 1: high from FILL through DRAIN.
REQ-020 Port done, output, 1: one-cycle pulse after the last write of a line.
REQ-021 Port overrun, output, 1: sticky flag, set when line_start arrives while busy.

Function
REQ-022 The FSM shall have four states: IDLE, FILL, DRAIN and DONE.
REQ-023 In IDLE, line_start=1 shall clear cur_x to 0, toggle buf_sel and enter FILL on the next cycle.
REQ-024 In FILL, each cycle shall select the lowest-index layer with layer_on set, drive that layer's address on rom_addr and push a {valid, hit, x} tag into a ROM_LAT-deep shift pipeline.
REQ-025 If no layer is on in FILL, rom_addr shall be 0 and the pushed tag shall have hit=0.
REQ-026 In FILL, cur_x shall increment by 1 per cycle; the transition to DRAIN shall occur in the cycle after the tag for cur_x=LINE_W-1 is issued.
REQ-027 DRAIN shall last exactly ROM_LAT cycles; DONE shall last 1 cycle, assert done, and then return to IDLE.
REQ-028 When a valid tag leaves the pipeline, wr_en shall be 1 and wr_x shall equal the tag's x.
REQ-029 For that write, wr_data shall be rom_data if hit=1 and rom_data != TRANSP_IDX; otherwise it shall be BG_IDX.
REQ-030 Exactly LINE_W writes shall occur per line, with wr_x strictly ascending from 0 to LINE_W-1 and no gaps.
REQ-031 Latency shall be constant: the write for column x shall occur exactly ROM_LAT cycles after cur_x=x was presented.
REQ-032 line_start while busy=1 or in DONE shall be ignored and shall set overrun; a simultaneous clear is not supported, and overrun is cleared only by Reset.
REQ-033 buf_sel shall not change during FILL, DRAIN or DONE.
REQ-034 cur_x shall hold LINE_W-1 through DRAIN and DONE, and shall be 0 in IDLE.

Reset
REQ-035 Reset shall be asynchronous and active-high; it shall force state IDLE, and cur_x, rom_addr, wr_x, wr_data and buf_sel to 0.
REQ-036 Reset shall force wr_en, busy, done and overrun to 0.
REQ-037 Reset shall clear every valid bit in the tag pipeline, so no write follows a mid-line reset.
REQ-038 After Reset deasserts, the first line_start shall set buf_sel=1.

Structure
REQ-039 A shared package shall hold the FSM state enum, the tag struct {valid, hit, x} and the default TRANSP_IDX and BG_IDX constants.
REQ-040 The priority selector shall be a separate sub-module, layer_priority_sel, parametrised by NUM_LAYERS and ADDR_W, that outputs {hit, addr}.
REQ-041 Apart from its registered inputs, the tag pipeline shall be the only sequential path between rom_addr and wr_data.

Verification
REQ-042 Scenario: defaults, layer_on=0 for the whole line, one line_start -> 640 writes of 1 at x=0..639, then done one cycle after the last write, and buf_sel=1.
REQ-043 Scenario: layer_on=4'b0110, layer 1 addr=0x100, layer 2 addr=0x200 -> rom_addr=0x100 every FILL cycle.
REQ-044 Scenario: the ROM model returns 0 for addr 0x100 and 5 otherwise, with layer 1 hit -> wr_data=1 (background); with layer 2 only hit -> wr_data=5.
REQ-045 Scenario: line_start pulsed at FILL cycle 10 -> overrun=1, writes unaffected, buf_sel unchanged; two clean lines -> buf_sel sequence 1, 0.
REQ-046 Scenario: Reset asserted at cur_x=300 -> all outputs 0 immediately, no wr_en after release, and the next line starts at x=0.
REQ-047 Scenario: parameters NUM_LAYERS=6, ROM_LAT=3, LINE_W=16 -> 16 writes, each exactly 3 cycles after its cur_x, layer-5-only hit honoured.

Source files
------------

// File: rtl/layer_compositor_pkg.sv
// Shared types and constants for the sprite-layer compositor: FSM states,
// the ROM-latency tag carried alongside each fetch, and default palette keys.
package layer_compositor_pkg;

  localparam int X_W            = 10;
  localparam int DEF_TRANSP_IDX = 0;
  localparam int DEF_BG_IDX     = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic           valid;
    logic           hit;
    logic [X_W-1:0] x;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, hit: 1'b0, x: '0};

endpackage

// File: rtl/layer_compositor_priority_sel.sv
// Fixed-priority layer picker: the lowest-index layer with its hit flag set
// wins and its ROM address is forwarded; no hit yields address 0.
module layer_priority_sel #(
  parameter int NUM_LAYERS = 4,
  parameter int ADDR_W     = 18
) (
  input  logic [NUM_LAYERS-1:0]        layer_on,
  input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
  output logic                         hit,
  output logic [ADDR_W-1:0]            addr
);

  // NOTE: every output gets a default before the loop, so no path through
  // this block leaves a value unassigned and no latch is inferred.
  always_comb begin
    hit  = 1'b0;
    addr = '0;
    // Walk from the lowest priority upwards so layer 0 overwrites last.
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_on[i]) begin
        hit  = 1'b1;
        addr = layer_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// Composites one line of sprite pixels into a ping-pong line buffer: fetches
// the winning layer's ROM index per column and writes it after ROM_LAT cycles.
module layer_compositor
  import layer_compositor_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int ADDR_W     = 18,
  parameter int IDX_W      = 4,
  parameter int LINE_W     = 640,
  parameter int ROM_LAT    = 2,
  parameter int TRANSP_IDX = DEF_TRANSP_IDX,
  parameter int BG_IDX     = DEF_BG_IDX
) (
  input  logic                         row_Clk,
  input  logic                         Reset,
  input  logic                         line_start,
  output logic [X_W-1:0]               cur_x,
  input  logic [NUM_LAYERS-1:0]        layer_on,
  input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
  output logic [ADDR_W-1:0]            rom_addr,
  input  logic [IDX_W-1:0]             rom_data,
  output logic                         wr_en,
  output logic [X_W-1:0]               wr_x,
  output logic [IDX_W-1:0]             wr_data,
  output logic                         buf_sel,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
);

  localparam int             CNT_W  = $clog2(ROM_LAT + 1);
  localparam logic [X_W-1:0] LAST_X = X_W'(LINE_W - 1);

  state_t           state, state_nxt;
  logic [X_W-1:0]   x_q, x_nxt;
  logic             buf_q, buf_nxt;
  logic             ovr_q, ovr_nxt;
  logic [CNT_W-1:0] drain_cnt, drain_cnt_nxt;

  logic              sel_hit;
  logic [ADDR_W-1:0] sel_addr;
  tag_t              push_tag;
  tag_t              out_tag;
  tag_t              pipe [ROM_LAT];

  layer_priority_sel #(
    .NUM_LAYERS (NUM_LAYERS),
    .ADDR_W     (ADDR_W)
  ) u_priority_sel (
    .layer_on   (layer_on),
    .layer_addr (layer_addr),
    .hit        (sel_hit),
    .addr       (sel_addr)
  );

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge row_Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      x_q       <= '0;
      buf_q     <= 1'b0;
      ovr_q     <= 1'b0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      x_q       <= x_nxt;
      buf_q     <= buf_nxt;
      ovr_q     <= ovr_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    x_nxt         = x_q;
    buf_nxt       = buf_q;
    drain_cnt_nxt = drain_cnt;
    push_tag      = TAG_NONE;
    // A request that arrives outside IDLE is dropped but remembered.
    ovr_nxt       = ovr_q | (line_start && (state != IDLE));

    case (state)
      IDLE: begin
        if (line_start) begin
          x_nxt     = '0;
          buf_nxt   = ~buf_q;
          state_nxt = FILL;
        end
      end
      FILL: begin
        push_tag = '{valid: 1'b1, hit: sel_hit, x: x_q};
        if (x_q == LAST_X) begin
          drain_cnt_nxt = '0;
          state_nxt     = DRAIN;
        end else begin
          x_nxt = x_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt == CNT_W'(ROM_LAT - 1)) begin
          state_nxt = DONE;
        end else begin
          drain_cnt_nxt = drain_cnt + 1'b1;
        end
      end
      DONE: begin
        x_nxt     = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the tag pipeline is a reset flop chain rather than a RAM, because a
  // stale valid bit surviving Reset would produce a spurious line-buffer write.
  always_ff @(posedge row_Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < ROM_LAT; i++) pipe[i] <= TAG_NONE;
    end else begin
      pipe[0] <= push_tag;
      for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign out_tag = pipe[ROM_LAT-1];

  // The tag emerges in the same cycle as the ROM data it describes.
  always_comb begin
    wr_data = '0;
    if (out_tag.valid) begin
      wr_data = (out_tag.hit && (rom_data != IDX_W'(TRANSP_IDX))) ? rom_data
                                                                  : IDX_W'(BG_IDX);
    end
  end

  assign wr_en    = out_tag.valid;
  assign wr_x     = out_tag.x;
  assign rom_addr = (state == FILL) ? sel_addr : '0;
  assign cur_x    = x_q;
  assign buf_sel  = buf_q;
  assign busy     = (state == FILL) || (state == DRAIN);
  assign done     = (state == DONE);
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: a default instance (640 px, ROM_LAT 2)
// and a small one (6 layers, ROM_LAT 3, 16 px) driven with directed lines.
module tb_layer_compositor;

  localparam int AW   = 18;
  localparam int IW   = 4;
  localparam int LA_N = 4;
  localparam int LA_W = 640;
  localparam int LA_L = 2;
  localparam int LB_N = 6;
  localparam int LB_W = 16;
  localparam int LB_L = 3;

  typedef struct packed {
    logic [9:0]    cur_x;
    logic [AW-1:0] rom_addr;
    logic [9:0]    wr_x;
    logic [IW-1:0] wr_data;
    logic          wr_en;
    logic          buf_sel;
    logic          busy;
    logic          done;
    logic          overrun;
  } obs_t;

  typedef struct {
    int x;
    int data;
  } exp_t;

  logic row_Clk = 1'b0;
  logic Reset;
  always #5 row_Clk = ~row_Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge row_Clk) cyc <= cyc + 1;

  // ---------------- instance A: defaults ----------------
  logic              start_a;
  logic [LA_N-1:0]   on_a;
  logic [LA_N*AW-1:0] addrs_a;
  logic [9:0]        cur_x_a, wr_x_a;
  logic [AW-1:0]     rom_addr_a;
  logic [IW-1:0]     rom_data_a, wr_data_a;
  logic              wr_en_a, buf_a, busy_a, done_a, ovr_a;

  layer_compositor u_dut_a (
    .row_Clk    (row_Clk),
    .Reset      (Reset),
    .line_start (start_a),
    .cur_x      (cur_x_a),
    .layer_on   (on_a),
    .layer_addr (addrs_a),
    .rom_addr   (rom_addr_a),
    .rom_data   (rom_data_a),
    .wr_en      (wr_en_a),
    .wr_x       (wr_x_a),
    .wr_data    (wr_data_a),
    .buf_sel    (buf_a),
    .busy       (busy_a),
    .done       (done_a),
    .overrun    (ovr_a)
  );

  // ---------------- instance B: 6 layers, ROM_LAT 3, 16 px ----------------
  logic              start_b;
  logic [LB_N-1:0]   on_b;
  logic [LB_N*AW-1:0] addrs_b;
  logic [9:0]        cur_x_b, wr_x_b;
  logic [AW-1:0]     rom_addr_b;
  logic [IW-1:0]     rom_data_b, wr_data_b;
  logic              wr_en_b, buf_b, busy_b, done_b, ovr_b;

  layer_compositor #(
    .NUM_LAYERS (LB_N),
    .ROM_LAT    (LB_L),
    .LINE_W     (LB_W)
  ) u_dut_b (
    .row_Clk    (row_Clk),
    .Reset      (Reset),
    .line_start (start_b),
    .cur_x      (cur_x_b),
    .layer_on   (on_b),
    .layer_addr (addrs_b),
    .rom_addr   (rom_addr_b),
    .rom_data   (rom_data_b),
    .wr_en      (wr_en_b),
    .wr_x       (wr_x_b),
    .wr_data    (wr_data_b),
    .buf_sel    (buf_b),
    .busy       (busy_b),
    .done       (done_b),
    .overrun    (ovr_b)
  );

  obs_t obs_a, obs_b;
  assign obs_a = {cur_x_a, rom_addr_a, wr_x_a, wr_data_a, wr_en_a, buf_a, busy_a, done_a, ovr_a};
  assign obs_b = {cur_x_b, rom_addr_b, wr_x_b, wr_data_b, wr_en_b, buf_b, busy_b, done_b, ovr_b};

  // Sprite ROM model: index 0 (transparent) at 0x100, 5 everywhere else.
  function automatic logic [IW-1:0] rom_f(input logic [AW-1:0] a);
    return (a == 18'h100) ? 4'd0 : 4'd5;
  endfunction

  logic [AW-1:0] romq_a [LA_L];
  logic [AW-1:0] romq_b [LB_L];
  always @(posedge row_Clk) begin
    romq_a[0] <= rom_addr_a;
    for (int i = 1; i < LA_L; i++) romq_a[i] <= romq_a[i-1];
    romq_b[0] <= rom_addr_b;
    for (int i = 1; i < LB_L; i++) romq_b[i] <= romq_b[i-1];
  end
  assign rom_data_a = rom_f(romq_a[LA_L-1]);
  assign rom_data_b = rom_f(romq_b[LB_L-1]);

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboards ----------------
  exp_t q_a[$];
  exp_t q_b[$];
  int   fill_cyc_a [LA_W];
  int   fill_cyc_b [LB_W];

  always @(negedge row_Clk) begin : mon_a
    exp_t e;
    if (wr_en_a) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_wr", 1, 0);
      end else begin
        e = q_a.pop_front();
        check("a_wr_x", wr_x_a, e.x);
        check("a_wr_data", wr_data_a, e.data);
        check("a_latency", cyc - fill_cyc_a[e.x], LA_L);
      end
    end
  end

  always @(negedge row_Clk) begin : mon_b
    exp_t e;
    if (wr_en_b) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_wr", 1, 0);
      end else begin
        e = q_b.pop_front();
        check("b_wr_x", wr_x_b, e.x);
        check("b_wr_data", wr_data_b, e.data);
        check("b_latency", cyc - fill_cyc_b[e.x], LB_L);
      end
    end
  end

  function automatic obs_t obs(input int w);
    return (w != 0) ? obs_b : obs_a;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w != 0) start_b = v;
    else        start_a = v;
  endtask

  task automatic check_zero(input string p, input obs_t o);
    check({p, "rst_cur_x"},    o.cur_x,    0);
    check({p, "rst_rom_addr"}, o.rom_addr, 0);
    check({p, "rst_wr_x"},     o.wr_x,     0);
    check({p, "rst_wr_data"},  o.wr_data,  0);
    check({p, "rst_wr_en"},    o.wr_en,    0);
    check({p, "rst_buf_sel"},  o.buf_sel,  0);
    check({p, "rst_busy"},     o.busy,     0);
    check({p, "rst_done"},     o.done,     0);
    check({p, "rst_overrun"},  o.overrun,  0);
  endtask

  // One line: expectations are queued up front; the FILL cycles are then
  // walked checking cur_x / rom_addr / buf_sel, then DRAIN and DONE timing.
  task automatic run_line(input int w, input logic [LB_N-1:0] on,
                          input logic [LB_N*AW-1:0] addrs, input int exp_addr,
                          input int exp_data, input logic exp_buf,
                          input int ovr_at, input int abort_at);
    int    n;
    int    lat;
    string p;
    obs_t  o;
    bit    seen;
    n   = (w != 0) ? LB_W : LA_W;
    lat = (w != 0) ? LB_L : LA_L;
    p   = (w != 0) ? "b_" : "a_";
    @(negedge row_Clk);
    if (w != 0) begin
      on_b = on; addrs_b = addrs;
    end else begin
      on_a = on[LA_N-1:0]; addrs_a = addrs[LA_N*AW-1:0];
    end
    for (int i = 0; i < n; i++) begin
      if (w != 0) q_b.push_back('{i, exp_data});
      else        q_a.push_back('{i, exp_data});
    end
    set_start(w, 1'b1);
    @(negedge row_Clk);
    set_start(w, 1'b0);
    for (int i = 0; i < n; i++) begin
      o = obs(w);
      check({p, "cur_x"},    o.cur_x,    i);
      check({p, "rom_addr"}, o.rom_addr, exp_addr);
      check({p, "buf_sel"},  o.buf_sel,  exp_buf);
      check({p, "busy"},     o.busy,     1);
      if (w != 0) fill_cyc_b[i] = cyc;
      else        fill_cyc_a[i] = cyc;
      if (i == abort_at) begin
        Reset = 1'b1;
        #1;
        check_zero(p, obs(w));
        q_a.delete();
        q_b.delete();
        repeat (2) @(negedge row_Clk);
        Reset = 1'b0;
        repeat (10) begin
          @(negedge row_Clk);
          o = obs(w);
          check({p, "wr_after_reset"}, o.wr_en, 0);
        end
        return;
      end
      set_start(w, i == ovr_at);
      @(negedge row_Clk);
    end
    set_start(w, 1'b0);
    seen = 1'b0;
    for (int k = 0; k <= lat + 3; k++) begin
      if (seen) break;
      o = obs(w);
      if (o.done) begin
        seen = 1'b1;
        check({p, "done_delay"},   k,         lat);
        check({p, "done_cur_x"},   o.cur_x,   n - 1);
        check({p, "done_busy"},    o.busy,    0);
        check({p, "done_buf_sel"}, o.buf_sel, exp_buf);
      end else if (k < lat) begin
        check({p, "drain_busy"},  o.busy,  1);
        check({p, "drain_cur_x"}, o.cur_x, n - 1);
      end
      @(negedge row_Clk);
    end
    if (!seen) check({p, "done_timeout"}, 0, 1);
    o = obs(w);
    check({p, "idle_done"},    o.done,    0);
    check({p, "idle_cur_x"},   o.cur_x,   0);
    check({p, "idle_busy"},    o.busy,    0);
    check({p, "idle_buf_sel"}, o.buf_sel, exp_buf);
    check({p, "sb_empty"}, (w != 0) ? q_b.size() : q_a.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LB_N*AW-1:0] av;
    Reset   = 1'b1;
    start_a = 1'b0; on_a = '0; addrs_a = '0;
    start_b = 1'b0; on_b = '0; addrs_b = '0;
    #1;
    check_zero("a_", obs_a);
    check_zero("b_", obs_b);
    repeat (3) @(negedge row_Clk);
    Reset = 1'b0;

    // Nothing on: every column is background, first buffer half is 1.
    run_line(0, '0, '0, 0, 1, 1'b1, -1, -1);

    // Layers 1 and 2 on: layer 1 wins, its ROM entry is transparent.
    av = '0;
    av[1*AW +: AW] = 18'h100;
    av[2*AW +: AW] = 18'h200;
    run_line(0, 6'b000110, av, 'h100, 1, 1'b0, -1, -1);
    check("a_overrun_clean", ovr_a, 0);

    // Layer 2 only, with a stray line_start at FILL cycle 10.
    run_line(0, 6'b000100, av, 'h200, 5, 1'b1, 10, -1);
    check("a_overrun_set", ovr_a, 1);

    // Mid-line reset at cur_x=300, then a clean line from x=0.
    run_line(0, 6'b000110, av, 'h100, 1, 1'b0, -1, 300);
    run_line(0, 6'b000100, av, 'h200, 5, 1'b1, -1, -1);

    // Small instance: only layer 5 hits, then layers 3 and 5.
    av = '0;
    av[5*AW +: AW] = 18'h3;
    run_line(1, 6'b100000, av, 'h3, 5, 1'b1, -1, -1);
    av[3*AW +: AW] = 18'h100;
    run_line(1, 6'b101000, av, 'h100, 1, 1'b0, -1, -1);
    check("b_overrun_clean", ovr_b, 0);

    repeat (5) @(negedge row_Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
